// File: rtl/mux_nx1_scan_reg.sv
// Registered N-channel multiplexer with manual select and masked round-robin auto-scan,
// presenting the chosen channel through a valid/ready output register.
module mux_nx1_scan_reg #(
    parameter int N_CH  = 8,
    parameter int DW    = 8,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 mode,
    input  logic [SEL_W-1:0]     sel,
    input  logic [N_CH-1:0]      ch_mask,
    input  logic [N_CH*DW-1:0]   in,
    output logic [DW-1:0]        out,
    output logic [SEL_W-1:0]     out_sel,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 err,
    output logic                 sweep_done
);

    localparam logic [SEL_W:0]   N_CH_W = (SEL_W+1)'(N_CH);
    localparam logic [SEL_W-1:0] LAST   = SEL_W'(N_CH - 1);

    logic [DW-1:0]     ch_data [N_CH];
    logic [SEL_W-1:0]  ptr, eff_ptr, auto_cur, hi_idx, cur;
    logic [2*N_CH-1:0] mask_rot;
    logic [SEL_W:0]    sum;
    logic              mode_q, sel_ok, cand_ok, free, ld;

    always_comb begin
        for (int k = 0; k < N_CH; k++) ch_data[k] = in[k*DW +: DW];
    end

    // Rotating a doubled mask makes bit k correspond to channel (eff_ptr + k) mod N_CH;
    // walking k downward leaves the nearest enabled channel as the final winner.
    always_comb begin
        eff_ptr  = (mode && !mode_q) ? '0 : ptr;
        mask_rot = {ch_mask, ch_mask} >> eff_ptr;
        auto_cur = '0;
        sum      = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (mask_rot[k]) begin
                sum = {1'b0, eff_ptr} + (SEL_W+1)'(k);
                if (sum >= N_CH_W) sum = sum - N_CH_W;
                auto_cur = sum[SEL_W-1:0];
            end
        end
    end

    always_comb begin
        hi_idx = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (ch_mask[i]) hi_idx = SEL_W'(i);
        end
    end

    always_comb begin
        sel_ok  = ({1'b0, sel} < N_CH_W);
        cur     = mode ? auto_cur : sel;
        cand_ok = mode ? (|ch_mask) : sel_ok;
        free    = !out_valid || out_ready;
        ld      = en && free && cand_ok;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out        <= '0;
            out_sel    <= '0;
            out_valid  <= 1'b0;
            err        <= 1'b0;
            sweep_done <= 1'b0;
            ptr        <= '0;
            mode_q     <= 1'b0;
        end else begin
            mode_q     <= mode;
            err        <= !mode && en && free && !sel_ok;
            sweep_done <= mode && ld && (cur == hi_idx);
            if (ld) begin
                out       <= ch_data[cur];
                out_sel   <= cur;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (mode && ld)
                ptr <= (cur == LAST) ? '0 : cur + 1'b1;
            else if (mode && !mode_q)
                ptr <= '0;
        end
    end

endmodule

// File: tb/tb_mux_nx1_scan_reg.sv
// Directed bench for mux_nx1_scan_reg: an 8-channel build for manual/auto/stall/reset
// behaviour and a 5-channel build for the out-of-range select error.
module tb_mux_nx1_scan_reg;

    logic        clk = 1'b0;
    logic        rst;
    // 8-channel instance
    logic        en, mode, out_ready, out_valid, err, sweep_done;
    logic [2:0]  sel, out_sel;
    logic [7:0]  ch_mask, out;
    logic [63:0] din;
    // 5-channel instance
    logic        en5, mode5, out_ready5, out_valid5, err5, sweep_done5;
    logic [2:0]  sel5, out_sel5;
    logic [4:0]  mask5;
    logic [7:0]  out5;
    logic [39:0] din5;

    int n_checks = 0;
    int n_fail   = 0;
    int ord [4]  = '{0, 2, 5, 7};
    int pos;

    mux_nx1_scan_reg #(.N_CH(8), .DW(8)) dut8 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel), .ch_mask(ch_mask),
        .in(din), .out(out), .out_sel(out_sel), .out_valid(out_valid),
        .out_ready(out_ready), .err(err), .sweep_done(sweep_done)
    );

    mux_nx1_scan_reg #(.N_CH(5), .DW(8)) dut5 (
        .clk(clk), .rst(rst), .en(en5), .mode(mode5), .sel(sel5), .ch_mask(mask5),
        .in(din5), .out(out5), .out_sel(out_sel5), .out_valid(out_valid5),
        .out_ready(out_ready5), .err(err5), .sweep_done(sweep_done5)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        en = 1'b1; mode = 1'b0; sel = 3'd0; ch_mask = 8'h00; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) din[i*8 +: 8] = 8'h10 + 8'(i);
        en5 = 1'b0; mode5 = 1'b0; sel5 = 3'd0; mask5 = 5'h00; out_ready5 = 1'b1;
        for (int i = 0; i < 5; i++) din5[i*8 +: 8] = 8'h50 + 8'(i);

        repeat (2) @(negedge clk);
        check("rst_out", out, 0);
        check("rst_out_sel", out_sel, 0);
        check("rst_valid", out_valid, 0);
        check("rst_err", err, 0);
        check("rst_sweep", sweep_done, 0);
        rst = 1'b0;

        // manual sweep 0..7
        for (int s = 0; s < 8; s++) begin
            sel = 3'(s);
            @(negedge clk);
            check($sformatf("man_out%0d", s), out, 8'h10 + s);
            check($sformatf("man_sel%0d", s), out_sel, s);
            check($sformatf("man_valid%0d", s), out_valid, 1);
        end

        // stall holds first capture while channel 3 changes
        sel = 3'd3;
        @(negedge clk);
        check("stall_first", out, 8'h13);
        out_ready = 1'b0;
        din[24 +: 8] = 8'hAA;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("stall_hold%0d", i), out, 8'h13);
            check($sformatf("stall_valid%0d", i), out_valid, 1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("stall_release", out, 8'hAA);
        din[24 +: 8] = 8'h13;

        // auto scan over mask 1010_0101
        mode = 1'b1;
        ch_mask = 8'b1010_0101;
        for (int r = 0; r < 8; r++) begin
            @(negedge clk);
            check($sformatf("auto_sel%0d", r), out_sel, ord[r % 4]);
            check($sformatf("auto_out%0d", r), out, 8'h10 + ord[r % 4]);
            check($sformatf("auto_sweep%0d", r), sweep_done, (ord[r % 4] == 7) ? 1 : 0);
        end

        // ready toggling: each channel once, no skips
        pos = 3;
        for (int i = 0; i < 8; i++) begin
            out_ready = (i % 2 == 0);
            @(negedge clk);
            if (i % 2 == 0) pos = (pos + 1) % 4;
            check($sformatf("tog_sel%0d", i), out_sel, ord[pos]);
            check($sformatf("tog_valid%0d", i), out_valid, 1);
        end

        // empty mask drains held sample then stays idle
        ch_mask = 8'h00;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("drain_valid%0d", i), out_valid, 0);
            check($sformatf("drain_sel%0d", i), out_sel, 7);
            check($sformatf("drain_err%0d", i), err, 0);
        end

        // reset mid-stream with ptr=5, then restart from lowest enabled
        ch_mask = 8'b0011_0000;
        @(negedge clk);
        check("pre_rst_sel", out_sel, 4);
        check("pre_rst_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_out", out, 0);
        check("mid_rst_sel", out_sel, 0);
        check("mid_rst_valid", out_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_sel", out_sel, 4);
        check("post_rst_out", out, 8'h14);
        check("post_rst_valid", out_valid, 1);

        // 5-channel build: out-of-range select
        en5 = 1'b1;
        sel5 = 3'd6;
        @(negedge clk);
        check("n5_err", err5, 1);
        check("n5_noload", out_valid5, 0);
        sel5 = 3'd4;
        @(negedge clk);
        check("n5_err_clear", err5, 0);
        check("n5_out", out5, 8'h54);
        check("n5_sel", out_sel5, 4);
        check("n5_valid", out_valid5, 1);
        mode5 = 1'b1;
        mask5 = 5'b00010;
        sel5 = 3'd7;
        @(negedge clk);
        check("n5_auto_noerr", err5, 0);
        check("n5_auto_sel", out_sel5, 1);
        check("n5_auto_sweep", sweep_done5, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_nx1_scan_reg.md
Name: mux_nx1_scan_reg

Overview:
- Parametrised, registered N-channel multiplexer: successor to the fixed combinational 8x1 mux family.
- Selects one DW-bit channel from a packed input bus and presents it through a valid/ready output register.
- Two modes: manual (external select) and auto-scan (round-robin over channels enabled in a mask, skipping masked channels).
- Sits in front of shared serial/monitor datapaths that sample many sources through one port.

Parameters:
- N_CH, 8, number of input channels (2..64, non-power-of-2 legal).
- DW, 8, data width per channel.
- SEL_W, $clog2(N_CH), select/pointer width (derived, do not override).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  load enable; 0 = no new samples captured.
- mode  input  1  0 = manual, 1 = auto-scan.
- sel  input  SEL_W  manual channel select.
- ch_mask  input  N_CH  auto-scan channel enables, bit i = channel i.
- in  input  N_CH*DW  packed channel data, channel i = in[i*DW +: DW].
- out  output  DW  registered selected data.
- out_sel  output  SEL_W  channel index of current out.
- out_valid  output  1  out/out_sel hold a sample.
- out_ready  input  1  downstream accepts the sample when out_valid && out_ready.
- err  output  1  one-cycle pulse: manual select out of range.
- sweep_done  output  1  one-cycle pulse: auto load of the highest enabled channel.

Behaviour:
- Reset (async, any time, including mid-transfer): out=0, out_sel=0, out_valid=0, err=0, sweep_done=0, scan pointer ptr=0, mode_q=0. Pending sample is dropped.
- Slot free: free = !out_valid || out_ready.
- Candidate channel:
  - Manual: cur = sel.
  - Auto: cur = first index c at or after ptr (ascending, wrapping N_CH-1 -> 0) with ch_mask[c]=1.
- Load condition: ld = en && free && cand_ok.
  - Manual: cand_ok = (sel < N_CH).
  - Auto: cand_ok = (ch_mask != 0).
- On ld (next edge):
  - out <= channel cur data; out_sel <= cur; out_valid <= 1.
  - Latency: one cycle from input sampling to out.
- No ld and out_valid && out_ready: out_valid <= 0; out and out_sel hold their last values.
- Stall: while out_valid && !out_ready, out/out_sel/out_valid are frozen and the pointer does not move.
- Simultaneous accept + load: a new sample replaces the old one in the same edge, giving back-to-back throughput of one sample per cycle.
- Auto pointer:
  - On each auto ld, ptr <= (cur == N_CH-1) ? 0 : cur+1.
  - Mask changes take effect at the next candidate evaluation.
  - Single enabled channel: the same channel is reloaded every ld.
- sweep_done = 1 for the cycle after an auto ld where cur is the highest set bit of ch_mask.
- Mode switch: mode_q registers mode each cycle. On the first cycle with mode=1 && mode_q=0, the candidate search starts from 0 (ptr treated as 0) and ptr is rewritten accordingly. Auto->manual leaves ptr unchanged.
- err:
  - 1 for the cycle after a cycle where manual mode, en && free, and sel >= N_CH; no load occurs.
  - Never asserted in auto mode. Only reachable when N_CH is not a power of 2.
- ch_mask==0 in auto mode: no loads, no err, any held sample still drains normally.
- en=0: no loads and the pointer holds; a held sample still drains on out_ready.

Test Plan:
- N_CH=8, DW=8, manual mode, in = channel i holds 8'h10+i, en=1, out_ready=1, sel sweeps 0..7 one per cycle -> out follows 8'h10..8'h17 with one-cycle lag, out_sel matching, out_valid=1 continuously.
- Manual mode, sel=3, out_ready=0 for 4 cycles while channel 3 data changes to 8'hAA -> out stays at the first-captured 8'h13 until out_ready rises, then 8'hAA on the next edge.
- Auto mode, ch_mask=8'b1010_0101, out_ready=1 -> out_sel sequence 0,2,5,7,0,2,... and sweep_done pulses with each out_sel=7 sample.
- Auto mode, toggle out_ready 1,0,1,0 -> each channel is delivered exactly once, with no skips or duplicates across stalls. Then ch_mask=0 -> out_valid drops after the last accept and stays 0.
- N_CH=5 build, manual, sel=3'd6, en=1 -> err pulses one cycle, out_valid stays 0. Then sel=4 -> out equals channel 4 data.
- Assert rst mid-stream with out_valid=1 and ptr=5 -> all outputs 0 immediately. After release in auto mode, the first sample is from the lowest enabled channel.
